// File: rtl/memory_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage (master) and data memory (slave).
interface memory_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  dmemReq;
  logic                  dmemWe;
  logic [DATA_WIDTH-1:0] dmemAddr;
  logic [DATA_WIDTH-1:0] dmemWdata;
  logic [3:0]            dmemBe;
  logic [DATA_WIDTH-1:0] dmemRdata;
  logic                  dmemAck;

  modport master (
    output dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    input  dmemRdata, dmemAck
  );

  modport slave (
    input  dmemReq, dmemWe, dmemAddr, dmemWdata, dmemBe,
    output dmemRdata, dmemAck
  );
endinterface

// File: rtl/memory_stage.sv
// Memory pipeline stage: data-memory load/store over req/ack, load formatting, write-back select into the M/W register.
// Aligned accesses take >=3 cycles (IDLE, REQ.., DONE) with stallM holding E/M; TIMEOUT REQ cycles without ack abort with busErrW.
module memory_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ROM_WIDTH  = 12,
  parameter int RF_WIDTH   = 5,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regWriteM,
  input  logic [1:0]            resultSelM,
  input  logic                  memWriteM,
  input  logic [2:0]            memCtrlM,
  input  logic [DATA_WIDTH-1:0] aluResultM,
  input  logic [DATA_WIDTH-1:0] memDinM,
  input  logic [RF_WIDTH-1:0]   regAddr3M,
  input  logic [ROM_WIDTH-1:0]  pcM,
  input  logic [DATA_WIDTH-1:0] immExtM,
  memory_stage_if.master        dmem,
  output logic                  stallM,
  output logic                  regWriteW,
  output logic [RF_WIDTH-1:0]   regAddr3W,
  output logic [DATA_WIDTH-1:0] regDin3W,
  output logic                  busErrW,
  output logic                  misalignW
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t                state, stateNext;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] loadBuf;
  logic                  errFlag;

  logic [1:0]            off;
  logic                  memOp, misal, accessGo;
  logic                  ackHit, timeoutHit, capture;
  logic [DATA_WIDTH-1:0] shifted, loadFmt, result;
  logic [ROM_WIDTH-1:0]  pcPlus4;

  assign off        = aluResultM[1:0];
  assign memOp      = memWriteM | (resultSelM == 2'b01);
  assign misal      = ((memCtrlM[1:0] == 2'b01) & off[0]) |
                      ((memCtrlM == 3'b010) & (off != 2'b00));
  assign accessGo   = memOp & ~misal;
  assign ackHit     = (state == REQ) & dmem.dmemAck;
  assign timeoutHit = (state == REQ) & ~dmem.dmemAck & (cnt == CW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accessGo) stateNext = REQ;
      REQ:     if (ackHit || timeoutHit) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Outputs; stallM is forced low while reset is asserted so E/M is released at once
  always_comb begin
    dmem.dmemReq = 1'b0;
    dmem.dmemWe  = 1'b0;
    stallM       = 1'b0;
    capture      = 1'b0;
    case (state)
      IDLE: begin
        stallM  = accessGo & rst_n;
        capture = ~accessGo;
      end
      REQ: begin
        dmem.dmemReq = 1'b1;
        dmem.dmemWe  = memWriteM;
        stallM       = rst_n;
      end
      DONE:    capture = 1'b1;
      default: capture = 1'b0;
    endcase
  end

  // Bus address, lane-replicated store data and byte enables come straight from the frozen E/M register
  always_comb begin
    dmem.dmemAddr = {aluResultM[DATA_WIDTH-1:2], 2'b00};
    case (memCtrlM[1:0])
      2'b00: begin
        dmem.dmemWdata = {4{memDinM[7:0]}};
        dmem.dmemBe    = 4'b0001 << off;
      end
      2'b01: begin
        dmem.dmemWdata = {2{memDinM[15:0]}};
        dmem.dmemBe    = off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        dmem.dmemWdata = memDinM;
        dmem.dmemBe    = 4'b1111;
      end
    endcase
  end

  assign shifted = loadBuf >> {off, 3'b000};
  assign pcPlus4 = pcM + ROM_WIDTH'(4);

  always_comb begin
    case (memCtrlM)
      3'b000:  loadFmt = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      3'b001:  loadFmt = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      3'b100:  loadFmt = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      3'b101:  loadFmt = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: loadFmt = shifted;
    endcase
    case (resultSelM)
      2'b00:   result = aluResultM;
      2'b01:   result = loadFmt;
      2'b10:   result = {{(DATA_WIDTH-ROM_WIDTH){1'b0}}, pcPlus4};
      default: result = immExtM;
    endcase
  end

  // Access bookkeeping: cycle counter, captured read data, timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      loadBuf <= '0;
      errFlag <= 1'b0;
    end else begin
      cnt <= (state == REQ) ? cnt + CW'(1) : '0;
      if (ackHit)          loadBuf <= dmem.dmemRdata;
      else if (timeoutHit) loadBuf <= '0;
      if (timeoutHit)          errFlag <= 1'b1;
      else if (state == DONE)  errFlag <= 1'b0;
    end
  end

  // M/W register; a bubble clears the control flags but leaves address/data as they were
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regWriteW <= 1'b0;
      regAddr3W <= '0;
      regDin3W  <= '0;
      busErrW   <= 1'b0;
      misalignW <= 1'b0;
    end else if (capture) begin
      regWriteW <= regWriteM & ~(memOp & misal);
      regAddr3W <= regAddr3M;
      regDin3W  <= result;
      busErrW   <= (state == DONE) & errFlag;
      misalignW <= memOp & misal;
    end else begin
      regWriteW <= 1'b0;
      busErrW   <= 1'b0;
      misalignW <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed-vector bench for memory_stage: issue task drives instructions and a memory responder, a monitor scores W outputs.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regWriteM;
  logic [1:0]  resultSelM;
  logic        memWriteM;
  logic [2:0]  memCtrlM;
  logic [31:0] aluResultM, memDinM, immExtM;
  logic [4:0]  regAddr3M;
  logic [11:0] pcM;
  logic        stallM, regWriteW, busErrW, misalignW;
  logic [4:0]  regAddr3W;
  logic [31:0] regDin3W;

  memory_stage_if #(.DATA_WIDTH(32)) dmem_if ();

  memory_stage #(.DATA_WIDTH(32), .ROM_WIDTH(12), .RF_WIDTH(5), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .regWriteM(regWriteM), .resultSelM(resultSelM), .memWriteM(memWriteM), .memCtrlM(memCtrlM),
    .aluResultM(aluResultM), .memDinM(memDinM), .regAddr3M(regAddr3M), .pcM(pcM), .immExtM(immExtM),
    .dmem(dmem_if),
    .stallM(stallM), .regWriteW(regWriteW), .regAddr3W(regAddr3W), .regDin3W(regDin3W),
    .busErrW(busErrW), .misalignW(misalignW)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] din;
    logic        err;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every W-register output carrying a write, error or misalign flag is scored in order
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && (regWriteW || busErrW || misalignW)) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_wb: got we=%0b err=%0b mis=%0b rd=%0d din=0x%08h, expected none",
                 regWriteW, busErrW, misalignW, regAddr3W, regDin3W);
      end else begin
        e = sb.pop_front();
        chk("wb.regWriteW", 32'(regWriteW), 32'(e.rw));
        chk("wb.busErrW",   32'(busErrW),   32'(e.err));
        chk("wb.misalignW", 32'(misalignW), 32'(e.mis));
        if (e.rw) begin
          chk("wb.regAddr3W", 32'(regAddr3W), 32'(e.rd));
          chk("wb.regDin3W",  regDin3W,       e.din);
        end
      end
    end
  end

  task automatic drive_idle();
    regWriteM = 1'b0; resultSelM = 2'b00; memWriteM = 1'b0; memCtrlM = 3'b010;
    aluResultM = '0; memDinM = '0; regAddr3M = '0; pcM = '0; immExtM = '0;
  endtask

  // Holds one instruction in M until it is captured; acts as data memory acking after ack_dly REQ cycles
  task automatic issue(input string nm, input logic [1:0] rs, input logic mw, input logic [2:0] mc,
                       input logic [31:0] alu, input logic [31:0] din, input logic [11:0] pc,
                       input logic [31:0] imm, input logic rw, input logic [4:0] rd,
                       input logic [31:0] rdata, input int ack_dly, input int exp_stall,
                       input logic exp_req, input logic chk_bus, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                       input logic exp_err, input logic exp_mis);
    exp_t e;
    int   n_stall = 0;
    int   n_req = 0;
    bit   done = 0;
    e = '{rw & ~exp_mis, rd, exp_res, exp_err, exp_mis};
    if (e.rw || e.err || e.mis) sb.push_back(e);
    regWriteM = rw; resultSelM = rs; memWriteM = mw; memCtrlM = mc;
    aluResultM = alu; memDinM = din; regAddr3M = rd; pcM = pc; immExtM = imm;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      if (dmem_if.dmemReq) begin
        if (n_req == 0) begin
          chk($sformatf("%s.dmemAddr", nm), dmem_if.dmemAddr, {alu[31:2], 2'b00});
          chk($sformatf("%s.dmemWe", nm), 32'(dmem_if.dmemWe), 32'(mw));
          if (chk_bus) begin
            chk($sformatf("%s.dmemBe", nm), 32'(dmem_if.dmemBe), 32'(exp_be));
            chk($sformatf("%s.dmemWdata", nm), dmem_if.dmemWdata, exp_wdata);
          end
        end
        n_req++;
        dmem_if.dmemAck   = (n_req > ack_dly);
        dmem_if.dmemRdata = rdata;
      end else begin
        dmem_if.dmemAck = 1'b0;
      end
      if (stallM) n_stall++;
      else        done = 1;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.capture: got stall still high after 60 cycles, expected release", nm);
    end else begin
      @(posedge clk);
      #1;
    end
    dmem_if.dmemAck = 1'b0;
    chk($sformatf("%s.stall_cycles", nm), 32'(n_stall), 32'(exp_stall));
    chk($sformatf("%s.req_seen", nm), 32'(n_req != 0), 32'(exp_req));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    dmem_if.dmemAck = 1'b0;
    dmem_if.dmemRdata = '0;
    drive_idle();
    repeat (2) @(negedge clk);
    chk("reset.dmemReq",   32'(dmem_if.dmemReq), 32'd0);
    chk("reset.stallM",    32'(stallM),          32'd0);
    chk("reset.regWriteW", 32'(regWriteW),       32'd0);
    chk("reset.regDin3W",  regDin3W,             32'd0);
    chk("reset.busErrW",   32'(busErrW),         32'd0);
    chk("reset.misalignW", 32'(misalignW),       32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //     name    rs     mw   mc      alu           din           pc      imm           rw  rd  rdata         dly st  req bus be       wdata         result        err mis
    issue("LW",    2'b01, 0, 3'b010, 32'h100, 32'h0,        12'h0,  32'h0,        1, 5, 32'hDEADBEEF, 0, 2,  1, 1, 4'b1111, 32'h0,        32'hDEADBEEF, 0, 0);
    issue("LB",    2'b01, 0, 3'b000, 32'h103, 32'h0,        12'h0,  32'h0,        1, 6, 32'h80FF0011, 0, 2,  1, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 0);
    issue("LBU",   2'b01, 0, 3'b100, 32'h103, 32'h0,        12'h0,  32'h0,        1, 7, 32'h80FF0011, 0, 2,  1, 0, 4'b0000, 32'h0,        32'h00000080, 0, 0);
    issue("LH",    2'b01, 0, 3'b001, 32'h102, 32'h0,        12'h0,  32'h0,        1, 8, 32'h80FF0011, 0, 2,  1, 0, 4'b0000, 32'h0,        32'hFFFF80FF, 0, 0);
    issue("LHU",   2'b01, 0, 3'b101, 32'h102, 32'h0,        12'h0,  32'h0,        1, 9, 32'h80FF0011, 0, 2,  1, 0, 4'b0000, 32'h0,        32'h000080FF, 0, 0);
    issue("SH",    2'b00, 1, 3'b001, 32'h202, 32'h1234ABCD, 12'h0,  32'h0,        0, 0, 32'h0,        0, 2,  1, 1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 0);
    issue("SB",    2'b00, 1, 3'b000, 32'h201, 32'h000000A5, 12'h0,  32'h0,        0, 0, 32'h0,        1, 3,  1, 1, 4'b0010, 32'hA5A5A5A5, 32'h0,        0, 0);
    issue("SW",    2'b00, 1, 3'b010, 32'h300, 32'hCAFEF00D, 12'h0,  32'h0,        0, 0, 32'h0,        0, 2,  1, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 0);
    issue("LHmis", 2'b01, 0, 3'b001, 32'h101, 32'h0,        12'h0,  32'h0,        1, 4, 32'h0,        0, 0,  0, 0, 4'b0000, 32'h0,        32'h0,        0, 1);
    issue("SWmis", 2'b00, 1, 3'b010, 32'h302, 32'h11223344, 12'h0,  32'h0,        0, 0, 32'h0,        0, 0,  0, 0, 4'b0000, 32'h0,        32'h0,        0, 1);
    issue("LWdly", 2'b01, 0, 3'b010, 32'h104, 32'h0,        12'h0,  32'h0,        1, 10, 32'h0BADF00D, 3, 5, 1, 0, 4'b0000, 32'h0,        32'h0BADF00D, 0, 0);
    issue("LWto",  2'b01, 0, 3'b010, 32'h400, 32'h0,        12'h0,  32'h0,        1, 11, 32'h55555555, 99, 16, 1, 0, 4'b0000, 32'h0,      32'h0,        1, 0);
    issue("ALU7",  2'b00, 0, 3'b000, 32'h7,   32'h0,        12'h0,  32'h0,        1, 12, 32'h0,       0, 0,  0, 0, 4'b0000, 32'h0,        32'h7,        0, 0);
    issue("PCwrap",2'b10, 0, 3'b000, 32'h0,   32'h0,        12'hFFC, 32'h0,       1, 13, 32'h0,       0, 0,  0, 0, 4'b0000, 32'h0,        32'h0,        0, 0);
    issue("PC4",   2'b10, 0, 3'b000, 32'h0,   32'h0,        12'h010, 32'h0,       1, 14, 32'h0,       0, 0,  0, 0, 4'b0000, 32'h0,        32'h14,       0, 0);
    issue("IMM",   2'b11, 0, 3'b000, 32'h0,   32'h0,        12'h0,  32'hFFFFF123, 1, 15, 32'h0,       0, 0,  0, 0, 4'b0000, 32'h0,        32'hFFFFF123, 0, 0);
    issue("ALU9",  2'b00, 0, 3'b000, 32'h9,   32'h0,        12'h0,  32'h0,        1, 16, 32'h0,       0, 0,  0, 0, 4'b0000, 32'h0,        32'h9,        0, 0);

    // Reset asserted while a load sits in REQ
    regWriteM = 1'b1; resultSelM = 2'b01; memWriteM = 1'b0; memCtrlM = 3'b010;
    aluResultM = 32'h500; regAddr3M = 5'd3;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid.req_before", 32'(dmem_if.dmemReq), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid.dmemReq",   32'(dmem_if.dmemReq), 32'd0);
    chk("rst_mid.stallM",    32'(stallM),          32'd0);
    chk("rst_mid.regWriteW", 32'(regWriteW),       32'd0);
    chk("rst_mid.regAddr3W", 32'(regAddr3W),       32'd0);
    chk("rst_mid.regDin3W",  regDin3W,             32'd0);
    chk("rst_mid.busErrW",   32'(busErrW),         32'd0);
    chk("rst_mid.misalignW", 32'(misalignW),       32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue("postrst",2'b00, 0, 3'b000, 32'h21,  32'h0,        12'h0,  32'h0,        1, 17, 32'h0,       0, 0,  0, 0, 4'b0000, 32'h0,        32'h21,       0, 0);
    drive_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute-to-memory register contents, performs data-memory loads and stores over a req/ack handshake, and formats load data (byte/half/word, signed/unsigned).
- Selects the write-back result and registers it into the memory-to-writeback register.
- Generates stallM, which freezes the execute-to-memory register while an access is outstanding.

Parameters:
- DATA_WIDTH, 32, datapath and memory word width.
- ROM_WIDTH, 12, PC width.
- RF_WIDTH, 5, register-file address width.
- TIMEOUT, 15, maximum REQ-state cycles without dmemAck before the access is aborted.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- regWriteM  in  1  write-back enable.
- resultSelM  in  2  result select: 00 ALU, 01 load, 10 pc+4, 11 immExt.
- memWriteM  in  1  store.
- memCtrlM  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- aluResultM  in  DATA_WIDTH  address or ALU result.
- memDinM  in  DATA_WIDTH  store data.
- regAddr3M  in  RF_WIDTH  destination register.
- pcM  in  ROM_WIDTH  instruction PC.
- immExtM  in  DATA_WIDTH  extended immediate.
- dmemReq  out  1  access request.
- dmemWe  out  1  write strobe.
- dmemAddr  out  DATA_WIDTH  word-aligned address.
- dmemWdata  out  DATA_WIDTH  lane-replicated store data.
- dmemBe  out  4  byte enables.
- dmemRdata  in  DATA_WIDTH  read data, valid when dmemAck=1.
- dmemAck  in  1  access complete.
- stallM  out  1  hold the execute-to-memory register.
- regWriteW  out  1  registered write enable.
- regAddr3W  out  RF_WIDTH  registered destination.
- regDin3W  out  DATA_WIDTH  registered write-back data.
- busErrW  out  1  registered timeout flag.
- misalignW  out  1  registered misalignment flag.

Behaviour:
- Access classification:
  - memOp = memWriteM | (resultSelM==01).
  - Misaligned when H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - A misaligned op issues no request and causes no stall; misalignW=1 and regWriteW=0 for that instruction.
- FSM states IDLE, REQ, DONE:
  - IDLE: aligned memOp gives stallM=1 (combinational); go to REQ. Otherwise stallM=0 and the W register captures normally.
  - REQ: dmemReq=1; dmemWe=memWriteM; addr/wdata/be held stable; stallM=1; counter increments each cycle.
    - On dmemAck: latch dmemRdata into loadBuf; go to DONE.
    - If the counter reaches TIMEOUT without ack: loadBuf=0, set errFlag; go to DONE.
  - DONE: dmemReq=0, stallM=0; the W register captures the instruction (busErrW=errFlag); counter and errFlag clear; go to IDLE.
    - The next instruction enters M on this same edge, so IDLE evaluates it fresh.
- Minimum aligned access: IDLE, REQ (ack in the first REQ cycle), DONE, giving stallM high for 2 cycles.
- While stallM=1, the W register loads a bubble: regWriteW=0, busErrW=0, misalignW=0.
- dmemAck outside REQ is ignored.
- Address: dmemAddr = {aluResultM[31:2], 2'b00}; off = aluResultM[1:0].
- Stores:
  - SB: wdata = 4 copies of byte[7:0]; be = 0001 << off.
  - SH: wdata = 2 copies of half[15:0]; be = off[1] ? 1100 : 0011.
  - SW: wdata = memDinM; be = 1111.
- Loads: shifted = loadBuf >> (8*off); extend low byte/half per funct3 (sign-extend for B/H, zero-extend for BU/HU); W passes through.
- Result select: 00 aluResultM; 01 formatted load; 10 zero-extended (pcM+4), wrapping modulo 2^ROM_WIDTH; 11 immExtM.
- Reset (asynchronous, any state including mid-REQ): state=IDLE, counter=0, loadBuf=0, dmemReq=0, all W outputs 0.
  - An aborted access is not retried; the pipeline refills after reset.

Test Plan:
- LW, addr 0x100, ack in the first REQ cycle, rdata 0xDEADBEEF -> stallM high exactly 2 cycles; regDin3W=0xDEADBEEF; regWriteW=1 one cycle after DONE; dmemAddr=0x100, be=1111.
- LB / LBU at addr 0x103, rdata 0x80FF0011 -> regDin3W=0xFFFFFF80 / 0x00000080.
- SH at addr 0x202, memDinM=0x1234ABCD -> dmemWe=1, be=1100, wdata=0xABCDABCD; regWriteW=0.
- LH at addr 0x101 -> no dmemReq; stallM=0; misalignW=1; regWriteW=0.
- Ack withheld for TIMEOUT cycles -> busErrW=1, regDin3W=0, FSM back in IDLE; a following ALU op (resultSel=00, aluResult=7) gives regDin3W=7 without stall.
- rst_n low during REQ -> dmemReq=0 and stallM=0 immediately; all W outputs 0.
- pcM=0xFFC, resultSel=10 -> regDin3W=0x00000000 (wrap).
